// File: rtl/syscall_input_port.sv
// syscall_input_port: debounced enter button feeding a small word FIFO that
// services the CPU's read syscall through an IDLE/WAIT/ACK handshake.
// Build option: define SYSCALL_INPUT_SIGNEXT_EN to sign-extend sw into the
// pushed word; the default build zero-extends.
module syscall_input_port #(
  parameter int unsigned DEBOUNCE_CYCLES = 4,
  parameter int unsigned FIFO_DEPTH_LOG2 = 2
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [15:0]              sw,
  input  logic                     btn_enter,
  input  logic                     rd_req,
  output logic [31:0]              rd_data,
  output logic                     rd_valid,
  output logic                     stall,
  output logic [FIFO_DEPTH_LOG2:0] fifo_count,
  output logic                     overflow
);

  localparam int unsigned DEPTH = 1 << FIFO_DEPTH_LOG2;
  localparam int unsigned CW    = $clog2(DEBOUNCE_CYCLES + 1);

  typedef enum logic [1:0] {IDLE, WAIT, ACK} state_e;

  logic                       sync1_q, sync2_q;
  logic                       db_level_q, db_level_d;
  logic [CW-1:0]              db_cnt_q, db_cnt_d;
  logic                       push, push_ok, pop, full;
  logic [31:0]                push_word;
  logic [31:0]                mem_q [DEPTH];
  logic [FIFO_DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [FIFO_DEPTH_LOG2:0]   count_q, count_d;
  logic                       overflow_q, overflow_d;
  logic [31:0]                rd_data_q, rd_data_d;
  state_e                     state_q, state_d;

`ifdef SYSCALL_INPUT_SIGNEXT_EN
  assign push_word = {{16{sw[15]}}, sw};
`else
  assign push_word = {16'b0, sw};
`endif

  // Debounce: count consecutive synchronized samples that differ from the
  // current level; flip after DEBOUNCE_CYCLES of them, pushing on a rise.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    push       = 1'b0;
    if (sync2_q != db_level_q) begin
      if (db_cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        db_level_d = sync2_q;
        push       = sync2_q;
      end else begin
        db_cnt_d = db_cnt_q + CW'(1);
      end
    end
  end

  // Read handshake: pop happens on the edge that enters ACK.
  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (rd_req) begin
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = ACK;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        if (!rd_req) begin
          state_d = IDLE;
        end else if (count_q != '0) begin
          pop     = 1'b1;
          state_d = ACK;
        end
      end
      ACK:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FIFO bookkeeping; a push into a full FIFO survives only if a pop frees a slot.
  always_comb begin
    full       = (count_q == (FIFO_DEPTH_LOG2 + 1)'(DEPTH));
    push_ok    = push & (~full | pop);
    overflow_d = overflow_q | (push & full & ~pop);
    wr_ptr_d   = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d   = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d    = count_q;
    if (push_ok && !pop)      count_d = count_q + 1'b1;
    else if (!push_ok && pop) count_d = count_q - 1'b1;
    rd_data_d  = pop ? mem_q[rd_ptr_q] : rd_data_q;
  end

  // State, synchronizer and control registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= 1'b0;
      sync2_q    <= 1'b0;
      db_level_q <= 1'b0;
      db_cnt_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rd_data_q  <= '0;
      state_q    <= IDLE;
    end else begin
      sync1_q    <= btn_enter;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rd_data_q  <= rd_data_d;
      state_q    <= state_d;
    end
  end

  // FIFO storage; contents are don't-care while the count says empty.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) mem_q[wr_ptr_q] <= push_word;
  end

  assign rd_data    = rd_data_q;
  assign rd_valid   = (state_q == ACK);
  assign stall      = rd_req & ~rd_valid;
  assign fifo_count = count_q;
  assign overflow   = overflow_q;

endmodule
